// File: rtl/serial_frame_tx.sv
// Buffered serial transmitter: collects DATA_W-bit entries, then sends them
// back-to-back as start/data/stop framed bits on a registered, idle-high line.
module serial_frame_tx #(
    parameter int MAX_BYTES    = 6,
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_W       = 8
) (
    input  logic                           clk,
    input  logic                           nRst,
    input  logic [DATA_W-1:0]              data,
    input  logic                           get,
    input  logic                           send,
    input  logic                           clear,
    output logic                           tx,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(MAX_BYTES+1)-1:0] level,
    output logic                           overflow
);

    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     baud_q, baud_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [IW-1:0]     byte_q, byte_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              wr_en;
    logic              bit_end;
    logic [BW-1:0]     nxt_bit;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] mem_q [MAX_BYTES];

    assign bit_end = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign nxt_bit = bit_q + BW'(1);
    assign cur     = mem_q[byte_q];

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            level_d = '0;
            ovf_d   = 1'b0;
            tx_d    = 1'b1;
        end else if (state_q == IDLE) begin
            if (get) begin
                if (level_q < LW'(MAX_BYTES)) begin
                    wr_en   = 1'b1;
                    level_d = level_q + LW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            // level_d already counts a byte appended in this same cycle
            if (send && level_d != '0) begin
                state_d = START;
                baud_d  = '0;
                byte_d  = '0;
                tx_d    = 1'b0;
            end
        end else begin
            if (get) ovf_d = 1'b1;
            baud_d = bit_end ? '0 : baud_q + CW'(1);
            if (bit_end) begin
                unique case (state_q)
                    START: begin
                        state_d = DATA;
                        bit_d   = '0;
                        tx_d    = cur[0];
                    end
                    DATA: begin
                        if (bit_q == BW'(DATA_W - 1)) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_d = nxt_bit;
                            tx_d  = cur[nxt_bit];
                        end
                    end
                    STOP: begin
                        if (LW'(byte_q) + LW'(1) == level_q) begin
                            state_d = IDLE;
                            level_d = '0;
                            done_d  = 1'b1;
                            tx_d    = 1'b1;
                        end else begin
                            state_d = START;
                            byte_d  = byte_q + IW'(1);
                            tx_d    = 1'b0;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[IW'(level_q)] <= data;
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign level    = level_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized bench for serial_frame_tx against a queue-based waveform model,
// plus directed frames with hand-computed expectations.
module tb_serial_frame_tx;

    localparam int MB  = 6;
    localparam int CPB = 4;
    localparam int DW  = 8;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [7:0] data = '0;
    logic       get = 1'b0;
    logic       send = 1'b0;
    logic       clear = 1'b0;
    logic       tx, busy, done, overflow;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    serial_frame_tx #(
        .MAX_BYTES(MB),
        .CLKS_PER_BIT(CPB),
        .DATA_W(DW)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .data(data),
        .get(get),
        .send(send),
        .clear(clear),
        .tx(tx),
        .busy(busy),
        .done(done),
        .level(level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Model: buffer as a queue; a running frame is the queue of per-cycle tx values.
    int mbuf[$];
    bit wave[$];
    bit m_done = 1'b0;
    bit m_ovf = 1'b0;

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            mbuf.delete();
            wave.delete();
            m_done = 1'b0;
            m_ovf  = 1'b0;
        end else if (clear) begin
            mbuf.delete();
            wave.delete();
            m_done = 1'b0;
            m_ovf  = 1'b0;
        end else if (wave.size() > 0) begin
            m_done = 1'b0;
            if (get) m_ovf = 1'b1;
            void'(wave.pop_front());
            if (wave.size() == 0) begin
                m_done = 1'b1;
                mbuf.delete();
            end
        end else begin
            m_done = 1'b0;
            if (get) begin
                if (mbuf.size() < MB) mbuf.push_back(int'(data));
                else m_ovf = 1'b1;
            end
            if (send && mbuf.size() > 0) begin
                foreach (mbuf[k]) begin
                    for (int j = 0; j < DW + 2; j++) begin
                        bit b;
                        if (j == 0) b = 1'b0;
                        else if (j == DW + 1) b = 1'b1;
                        else b = bit'((mbuf[k] >> (j - 1)) & 1);
                        for (int c = 0; c < CPB; c++) wave.push_back(b);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic       m_tx, m_busy;
        logic [2:0] m_level;
        m_busy  = (wave.size() > 0);
        m_tx    = m_busy ? wave[0] : 1'b1;
        m_level = 3'(mbuf.size());
        checks++;
        if ({tx, busy, done, level, overflow} !==
            {m_tx, m_busy, m_done, m_level, m_ovf}) begin
            errors++;
            $display("FAIL model t=%0t tx/busy/done/level/ovf got %b %b %b %0d %b exp %b %b %b %0d %b",
                     $time, tx, busy, done, level, overflow,
                     m_tx, m_busy, m_done, m_level, m_ovf);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, act, exp);
        end
    endtask

    task automatic do_get(input logic [7:0] d);
        get  = 1'b1;
        data = d;
        tick();
        get = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_done timeout got done=%b exp 1", done);
        end
    endtask

    logic       samp [40];
    logic [9:0] pat;
    logic       ok;
    logic       early;

    initial begin
        pat = 10'b1101001010;
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        nRst = 1'b1;

        // single byte 0xA5
        do_get(8'hA5);
        chk("a5_level", level, 1);
        send = 1'b1;
        tick();
        send = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            samp[i] = tx;
            if (done) early = 1'b1;
            tick();
        end
        chk("a5_done40", done, 1);
        chk("a5_noearly", early, 0);
        chk("a5_busy", busy, 0);
        chk("a5_level0", level, 0);
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < 4; c++) if (samp[4*b+c] !== pat[b]) ok = 1'b0;
            chk($sformatf("a5_bit%0d", b), {31'd0, samp[4*b]} | {31'd0, ~ok}, {31'd0, pat[b]});
        end
        tick();

        // full buffer
        for (int v = 1; v <= 6; v++) do_get(8'(v));
        chk("full_level", level, 6);
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_done(400);
        chk("full_level0", level, 0);
        chk("full_ovf", overflow, 0);
        tick();

        // overflow
        for (int v = 0; v < 7; v++) do_get(8'($urandom));
        chk("ovf_level", level, 6);
        chk("ovf_flag", overflow, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_level", level, 0);
        do_get(8'h81);
        send = 1'b1;
        tick();
        send = 1'b0;
        do_get(8'h55);
        chk("busy_get_ovf", overflow, 1);
        wait_done(100);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // empty send
        send = 1'b1;
        tick();
        send = 1'b0;
        chk("empty_busy", busy, 0);
        chk("empty_tx", tx, 1);
        chk("empty_done", done, 0);
        tick();
        chk("empty_done2", done, 0);

        // simultaneous get and send
        data = 8'h3C;
        get  = 1'b1;
        send = 1'b1;
        tick();
        get  = 1'b0;
        send = 1'b0;
        chk("gs_busy", busy, 1);
        chk("gs_tx", tx, 0);
        wait_done(100);
        tick();

        // abort during data of byte 2
        for (int v = 0; v < 3; v++) do_get(8'($urandom));
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (50) tick();
        chk("ab_busy_before", busy, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ab_tx", tx, 1);
        chk("ab_busy", busy, 0);
        chk("ab_level", level, 0);
        chk("ab_done", done, 0);
        tick();
        chk("ab_done2", done, 0);

        // async reset mid-frame
        for (int v = 0; v < 3; v++) do_get(8'h00);
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (20) tick();
        #2;
        nRst = 1'b0;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_busy", busy, 0);
        chk("arst_level", level, 0);
        tick();
        nRst = 1'b1;
        do_get(8'h77);
        chk("arst_first_get", level, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // random traffic
        repeat (4000) begin
            get   = ($urandom_range(0, 99) < 30);
            send  = ($urandom_range(0, 99) < 6);
            clear = ($urandom_range(0, 199) < 3);
            data  = 8'($urandom);
            tick();
        end
        get   = 1'b0;
        send  = 1'b0;
        clear = 1'b0;
        repeat (300) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 6: buffer depth in bytes, legal range 1..64.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 1: clock cycles per serial bit, legal range 1..65535.
REQ-003 SHALL have parameter DATA_W, default 8: bits per buffer entry, legal range 5..9.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with the ports listed in REQ-005 and REQ-006.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 nRst  input  1  asynchronous active-low reset.
REQ-007 data  input  DATA_W  byte to append to the buffer.
REQ-008 get  input  1  append strobe; samples data in the same cycle.
REQ-009 send  input  1  start transmission of the buffer contents.
REQ-010 clear  input  1  empty the buffer, clear overflow, abort any transmission.
REQ-011 tx  output  1  serial line, registered, idle high.
REQ-012 busy  output  1  high while a frame is being transmitted.
REQ-013 done  output  1  one-cycle pulse when a frame completes.
REQ-014 level  output  clog2(MAX_BYTES+1)  number of bytes currently buffered.
REQ-015 overflow  output  1  sticky flag: a get was dropped.

Function
REQ-016 SHALL implement states IDLE, START, DATA, STOP; busy SHALL be high in every state except IDLE.
REQ-017 In IDLE, get with level<MAX_BYTES SHALL write data at index level, and level SHALL increment by 1.
REQ-018 In IDLE, get with level==MAX_BYTES SHALL drop data, leave level unchanged, and set overflow.
REQ-019 In any non-IDLE state, get SHALL be dropped and SHALL set overflow.
REQ-020 In IDLE, send with level>0 SHALL enter START on the next edge; tx SHALL go low in the first cycle after that edge.
REQ-021 In IDLE, send with level==0 SHALL be ignored: no state change and no done pulse.
REQ-022 In IDLE, simultaneous get and send SHALL apply the get first; the new byte SHALL be included in the frame.
REQ-023 The frame SHALL transmit bytes in write order, index 0 first.
REQ-024 Each byte SHALL be framed as: one start bit (0), then DATA_W data bits LSB first, then one stop bit (1).
REQ-025 Every bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts at each bit boundary.
REQ-026 An N-byte frame SHALL occupy exactly N*(DATA_W+2)*CLKS_PER_BIT cycles of tx, with no idle gap between bytes.
REQ-027 Transition STOP to START SHALL occur when bytes remain; STOP to IDLE SHALL occur after the last stop bit.
REQ-028 On return to IDLE, done SHALL pulse for exactly one cycle, busy SHALL fall in that same cycle, and level SHALL read 0.
REQ-029 send while busy SHALL be ignored.
REQ-030 clear in IDLE SHALL set level to 0 and overflow to 0 on the next edge.
REQ-031 clear while busy SHALL abort the frame on the next edge: state IDLE, tx=1, level=0, overflow=0, and no done pulse.
REQ-032 clear SHALL take priority over get and send in the same cycle.
REQ-033 Buffer storage contents SHALL NOT require reset; only control state is reset.

Reset
REQ-034 While nRst=0, outputs SHALL be tx=1, busy=0, done=0, level=0, overflow=0, and the state SHALL be IDLE.
REQ-035 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously) and discard the buffer.
REQ-036 After reset release, the first get SHALL be accepted on the first rising edge.

Verification
REQ-037 Single byte (MAX_BYTES=6, CLKS_PER_BIT=4): get 0xA5, then send -> tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; done pulses 40 cycles after tx first falls.
REQ-038 Full buffer: 6 gets of 0x01..0x06, then send -> 60 contiguous bits, bytes in order 0x01..0x06; level returns 0 with done; overflow=0.
REQ-039 Overflow: 7 gets in IDLE -> level=6 and overflow=1; a get during busy also sets overflow; clear in IDLE returns overflow to 0.
REQ-040 Empty send: send with level=0 -> tx stays 1, busy stays 0, no done pulse.
REQ-041 Simultaneous get(0x3C) and send with level=0 -> one-byte frame of 0x3C is transmitted.
REQ-042 Abort: clear during the DATA state of byte 2 of 3 -> next cycle tx=1, busy=0, level=0, no done pulse; nRst pulsed mid-frame gives the same result asynchronously.
